// File: rtl/csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder
//
// Pipelined multi-operand adder. N_OPS operands of WIDTH bits are extended to
// SUM_W bits and reduced by a chain of 3:2 carry-save rows to one sum/carry
// pair, which is registered in stage 1. Stage 2 resolves the pair with a
// carry-propagate adder into sum_out. Valid/ready handshakes on both sides
// give one operand set per cycle of throughput and two cycles of latency.
//
// Build option:
//   CSA_SIGNED_EN  defined   -> operands are two's complement (sign-extended)
//                  undefined -> operands are unsigned (zero-extended)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   ops_in carries a valid operand set
//   in_ready   block accepts an operand set this cycle
//   ops_in     packed operands, operand k at [k*WIDTH +: WIDTH]
//   out_valid  sum_out holds a valid result
//   out_ready  consumer accepts sum_out this cycle
//   sum_out    exact sum of one accepted operand set
// ---------------------------------------------------------------------------
module csa_pipe_adder #(
  parameter int N_OPS = 8,
  parameter int WIDTH = 4,
  parameter int SUM_W = WIDTH + $clog2(N_OPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OPS*WIDTH-1:0] ops_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_W-1:0]       sum_out
);

  localparam int EXT_W = SUM_W - WIDTH;

  logic [SUM_W-1:0] row_sum;
  logic [SUM_W-1:0] row_carry;
  logic [SUM_W-1:0] addend;
  logic [SUM_W-1:0] next_sum;
  logic [SUM_W-1:0] next_carry;

  logic [SUM_W-1:0] s1_sum;
  logic [SUM_W-1:0] s1_carry;
  logic             s1_valid;

  logic             adv1;
  logic             adv2;

  // Widen one operand to the result width; the sign bit is replicated only
  // in the signed build.
  function automatic logic [SUM_W-1:0] extend(input logic [WIDTH-1:0] v);
`ifdef CSA_SIGNED_EN
    return {{EXT_W{v[WIDTH-1]}}, v};
`else
    return {{EXT_W{1'b0}}, v};
`endif
  endfunction

  // Carry-save reduction: the first two operands seed the sum/carry pair and
  // each further operand folds in through one full-adder row. Carries are
  // shifted left and truncated; wrap-around is harmless because the true sum
  // always fits in SUM_W bits.
  always_comb begin
    row_sum    = extend(ops_in[0 +: WIDTH]);
    row_carry  = extend(ops_in[WIDTH +: WIDTH]);
    addend     = '0;
    next_sum   = '0;
    next_carry = '0;
    for (int k = 2; k < N_OPS; k++) begin
      addend     = extend(ops_in[k*WIDTH +: WIDTH]);
      next_sum   = row_sum ^ row_carry ^ addend;
      next_carry = ((row_sum & row_carry) | (row_sum & addend) |
                    (row_carry & addend)) << 1;
      row_sum    = next_sum;
      row_carry  = next_carry;
    end
  end

  // Handshake: stage 2 advances when it is empty or being drained; stage 1
  // can take new data when empty or when its content moves on this cycle.
  always_comb begin
    adv2     = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || adv2;
    adv1     = in_valid && in_ready;
  end

  // Stage 1 register: carry-save pair plus its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum   <= '0;
      s1_carry <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (adv1) begin
        s1_sum   <= row_sum;
        s1_carry <= row_carry;
      end
      if (adv1) begin
        s1_valid <= 1'b1;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 register: final carry-propagate add; the result holds under
  // backpressure and valid drops only once the consumer has taken it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (adv2) begin
        sum_out   <= s1_sum + s1_carry;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_csa_pipe_adder
//
// Directed bench for csa_pipe_adder. The driver pushes each accepted set's
// hand-computed result into a queue; a monitor pops and compares whenever a
// result leaves the DUT. Two small extra instances cover the parameter
// extremes. Expected values follow CSA_SIGNED_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_csa_pipe_adder;

`ifdef CSA_SIGNED_EN
  localparam logic [6:0] EXP_ALL_F = 7'h78;
  localparam logic [6:0] EXP_ROT   = 7'd20;
  localparam logic [9:0] EXP_OPS3  = 10'h3FD;
`else
  localparam logic [6:0] EXP_ALL_F = 7'd120;
  localparam logic [6:0] EXP_ROT   = 7'd36;
  localparam logic [9:0] EXP_OPS3  = 10'd765;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ops_in;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  sum_out;

  logic        small_valid;
  logic [23:0] ops3;
  logic        ready3;
  logic        valid3;
  logic [9:0]  sum3;
  logic [15:0] ops16;
  logic        ready16;
  logic        valid16;
  logic [4:0]  sum16;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [6:0]  exp_q[$];
  logic [6:0]  cur_exp;

  always #5 clk = ~clk;

  csa_pipe_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ops_in(ops_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out)
  );

  csa_pipe_adder #(.N_OPS(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(small_valid), .in_ready(ready3),
    .ops_in(ops3), .out_valid(valid3), .out_ready(1'b1), .sum_out(sum3)
  );

  csa_pipe_adder #(.N_OPS(16), .WIDTH(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(small_valid), .in_ready(ready16),
    .ops_in(ops16), .out_valid(valid16), .out_ready(1'b1), .sum_out(sum16)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Present one set and hold it until accepted; the monitor records the
  // expected result at the accepting edge.
  task automatic applyStimulus(input logic [31:0] ops, input logic [6:0] exp);
    bit got;
    got      = 1'b0;
    ops_in   = ops;
    cur_exp  = exp;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_queue", exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] allSame(input logic [3:0] v);
    return {8{v}};
  endfunction

  // Scoreboard: capture accepted sets and compare delivered results, both
  // sampled half a cycle before the edge that completes the handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) checkOutput("unexpected_result", 32'd1, 32'd0);
        else checkOutput("scoreboard_sum", sum_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] vec;
    logic [3:0]  v;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    ops_in      = '0;
    cur_exp     = '0;
    small_valid = 1'b0;
    ops3        = '0;
    ops16       = '0;
    #1;
    checkOutput("reset_in_ready", in_ready, 32'd1);
    checkOutput("reset_out_valid", out_valid, 32'd0);
    checkOutput("reset_sum_out", sum_out, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_out_valid", out_valid, 32'd0);

    // Single set and two-cycle latency
    applyStimulus(allSame(4'hF), EXP_ALL_F);
    checkOutput("latency_edge1_valid", out_valid, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_edge2_valid", out_valid, 32'd1);
    checkOutput("latency_edge2_sum", sum_out, {25'd0, EXP_ALL_F});
    waitIdle();

    applyStimulus(allSame(4'h0), 7'd0);
    applyStimulus(allSame(4'h8), 7'h40);
    applyStimulus(allSame(4'h7), 7'd56);
    waitIdle();

    // Back-to-back rotated sets 1..8
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        v = 4'(((k + r) % 8) + 1);
        vec[k*4 +: 4] = v;
      end
      applyStimulus(vec, EXP_ROT);
      if (r >= 2) checkOutput("stream_out_valid", out_valid, 32'd1);
    end
    waitIdle();

    // Backpressure: A and B buffered, C stalled until the consumer drains
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(allSame(4'h1), 7'd8);
        applyStimulus(allSame(4'h2), 7'd16);
        applyStimulus(allSame(4'h3), 7'd24);
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_in_ready", in_ready, 32'd0);
    checkOutput("bp_out_valid", out_valid, 32'd1);
    checkOutput("bp_sum_hold", sum_out, 32'd8);
    @(posedge clk);
    #1;
    checkOutput("bp_sum_hold2", sum_out, 32'd8);
    out_ready = 1'b1;
    wait fork;
    waitIdle();

    // Reset with two sets in flight
    applyStimulus(allSame(4'h1), 7'd8);
    applyStimulus(allSame(4'h2), 7'd16);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 32'd0);
    checkOutput("midreset_sum_out", sum_out, 32'd0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_stale_result", out_valid, 32'd0);
    end

    // Parameter extremes
    @(posedge clk);
    #1;
    ops3        = {3{8'hFF}};
    ops16       = 16'hFFFF;
    small_valid = 1'b1;
    @(posedge clk);
    #1;
    small_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ops3_valid", valid3, 32'd1);
    checkOutput("ops3_sum", sum3, {22'd0, EXP_OPS3});
    checkOutput("ops16_valid", valid16, 32'd1);
    checkOutput("ops16_sum", sum16, 32'd16);

    waitIdle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
